load_store_unit: RTL

- Initiator side of the CPU data-memory interface.
- Accepts one load or store per request from the execute/memory stage.
- Drives the data memory's read-enable/write-enable/address/data pins, honouring its 1-cycle registered read and negedge write.
- Performs byte/halfword lane steering, read-modify-write for sub-word stores, and sign/zero extension for loads.

---
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the CPU data-memory port (1-cycle registered read, negedge write).
// Optional misalignment rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit #(
  parameter int bus     = 32,
  parameter int memsize = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_signed,
  input  logic [bus-1:0] req_addr,
  input  logic [bus-1:0] req_wdata,
  output logic           resp_valid,
  output logic [bus-1:0] resp_rdata,
  output logic           resp_err,
  output logic [bus-1:0] datain,
  output logic [bus-1:0] writedir,
  output logic [bus-1:0] readdir,
  input  logic [bus-1:0] dataout,
  output logic           MRE,
  output logic           MWE
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, CAP, WR, DONE} state_t;

  localparam logic [bus-1:0] MEM_WORDS = bus'(memsize);

  state_t         state_q;
  logic           we_q;
  logic [1:0]     size_q;
  logic           signed_q;
  logic [1:0]     off_q;
  logic [bus-1:0] addr_q;
  logic [bus-1:0] wdata_q;
  logic [bus-1:0] datain_q;
  logic [bus-1:0] resp_rdata_q;
  logic           resp_valid_q;
  logic           resp_err_q;
  logic           mre_q;
  logic           mwe_q;

  logic           err_d;
  logic [bus-1:0] rdata_d;
  logic [bus-1:0] merge_d;

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    r = 32'h0000_0000;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store's low byte/half onto the addressed lane, keeping the others.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else begin
      if (off[1]) r[31:16] = wdata[15:0];
      else        r[15:0]  = wdata[15:0];
    end
    return r;
  endfunction

  // Reject illegal size, out-of-range word index and (optionally) misaligned requests.
  always_comb begin
    err_d = 1'b0;
    if (req_size == 2'b11) begin
      err_d = 1'b1;
    end else if ({2'b00, req_addr[bus-1:2]} >= MEM_WORDS) begin
      err_d = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
    end else if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end else if ((req_size == 2'b01) && req_addr[0]) begin
      err_d = 1'b1;
`endif
    end else begin
      err_d = 1'b0;
    end
  end

  assign rdata_d = lane_extract(dataout, off_q, size_q, signed_q);
  assign merge_d = lane_merge(dataout, wdata_q, off_q, size_q);

  // Request sequencer with registered memory strobes and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      datain_q     <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mre_q        <= 1'b0;
      mwe_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            signed_q     <= req_signed;
            off_q        <= req_addr[1:0];
            addr_q       <= {req_addr[bus-1:2], 2'b00};
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            if (err_d) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && (req_size == 2'b10)) begin
              state_q  <= WR;
              datain_q <= req_wdata;
              mwe_q    <= 1'b1;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state_q <= RD;
              mre_q   <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          mre_q   <= 1'b0;
          state_q <= we_q ? MERGE : CAP;
        end
        MERGE: begin
          datain_q <= merge_d;
          mwe_q    <= 1'b1;
          state_q  <= WR;
        end
        CAP: begin
          resp_rdata_q <= rdata_d;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        WR: begin
          mwe_q        <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          mre_q        <= 1'b0;
          mwe_q        <= 1'b0;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign datain     = datain_q;
  // The memory indexes writes with readdir, so both addresses share one register.
  assign writedir   = addr_q;
  assign readdir    = addr_q;
  assign MRE        = mre_q;
  assign MWE        = mwe_q;

endmodule
